// File: rtl/otter_fetch_queue.sv
// otter_fetch_queue
//   Instruction prefetch queue for the pipelined Otter. Owns the fetch PC,
//   issues sequential fetches to instruction memory, buffers returned
//   instructions together with their PC, and presents the head entry to
//   decode on a valid/ready handshake. A redirect from execute flushes all
//   queued and in-flight fetches and restarts fetching at the target.
//
// Ports
//   CLK          clock, all state updates on the rising edge
//   RST          synchronous active-high reset
//   REDIRECT     flush and restart fetch at REDIRECT_PC
//   REDIRECT_PC  redirect target
//   MEM_ADDR     instruction fetch address
//   MEM_RDEN     fetch request this cycle
//   MEM_DATA     instruction data, valid the cycle after MEM_RDEN
//   OUT_VALID    head entry valid
//   OUT_READY    decode accepts the head entry this cycle
//   OUT_INSTR    head instruction (NOP_INSTR when empty)
//   OUT_PC       head PC (0 when empty)
//   OUT_PCPLUS4  head PC + 4 (0 when empty)
//   COUNT        number of buffered entries
module otter_fetch_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         REDIRECT,
    input  logic [31:0]                  REDIRECT_PC,
    output logic [31:0]                  MEM_ADDR,
    output logic                         MEM_RDEN,
    input  logic [31:0]                  MEM_DATA,
    output logic                         OUT_VALID,
    input  logic                         OUT_READY,
    output logic [31:0]                  OUT_INSTR,
    output logic [31:0]                  OUT_PC,
    output logic [31:0]                  OUT_PCPLUS4,
    output logic [$clog2(DEPTH+1)-1:0]   COUNT
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]   fetchPc;
    logic          inflight;
    logic [31:0]   inflightPc;
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] wrPtr;
    logic [CW-1:0] count;

    logic [31:0]   instrMem [DEPTH];
    logic [31:0]   pcMem    [DEPTH];

    logic [CW:0]   used;
    logic          push;
    logic          pop;

    // Credits count buffered entries plus the fetch still in flight, so a
    // response always has a free slot; a same-cycle pop does not free one.
    always_comb begin
        used      = {1'b0, count} + (CW + 1)'(inflight);
        MEM_RDEN  = ~RST & (REDIRECT | (used < DEPTH_W));
        MEM_ADDR  = REDIRECT ? REDIRECT_PC : fetchPc;
        OUT_VALID = (count != '0);
        push      = inflight & ~REDIRECT;
        pop       = OUT_VALID & OUT_READY & ~REDIRECT;
    end

    always_comb begin
        OUT_INSTR   = NOP_INSTR;
        OUT_PC      = '0;
        OUT_PCPLUS4 = '0;
        if (OUT_VALID) begin
            OUT_INSTR   = instrMem[rdPtr];
            OUT_PC      = pcMem[rdPtr];
            OUT_PCPLUS4 = pcMem[rdPtr] + 32'd4;
        end
    end

    assign COUNT = count;

    always_ff @(posedge CLK) begin
        if (RST) begin
            fetchPc    <= RESET_PC;
            inflight   <= 1'b0;
            inflightPc <= '0;
            rdPtr      <= '0;
            wrPtr      <= '0;
            count      <= '0;
        end else begin
            if (MEM_RDEN) begin
                fetchPc    <= MEM_ADDR + 32'd4;
                inflight   <= 1'b1;
                inflightPc <= MEM_ADDR;
            end else begin
                inflight   <= 1'b0;
            end

            if (REDIRECT) begin
                rdPtr <= '0;
                wrPtr <= '0;
                count <= '0;
            end else begin
                if (push) wrPtr <= wrPtr + PW'(1);
                if (pop)  rdPtr <= rdPtr + PW'(1);
                if (push && !pop)      count <= count + CW'(1);
                else if (pop && !push) count <= count - CW'(1);
            end
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge CLK) begin
        if (!RST && push) begin
            instrMem[wrPtr] <= MEM_DATA;
            pcMem[wrPtr]    <= inflightPc;
        end
    end

endmodule
